// File: rtl/mod_counter_pkg.sv
// Shared types and helpers for the mod_counter block: FSM state encoding and
// the terminal-value helper used for load clamping and wrap decode.
package mod_counter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Terminal value of a modulo-N sequence; callers size it to WIDTH with a cast.
  function automatic int unsigned last_value(input int unsigned modulus);
    return modulus - 1;
  endfunction

endpackage

// File: rtl/mod_counter_next.sv
// Combinational next-count, wrap and terminal decode for mod_counter.
// Up/down counting is compiled in when UPDOWN_EN is defined.
module mod_counter_next
  import mod_counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic [WIDTH-1:0] q,
`ifdef UPDOWN_EN
  input  logic             up_dn,
`endif
  output logic [WIDTH-1:0] q_adv,
  output logic             at_term,
  output logic [WIDTH-1:0] restart_val
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(last_value(MODULUS));

  // NOTE: every output gets a default first so no path through the block can infer a latch.
  always_comb begin
    q_adv       = q;
    at_term     = 1'b0;
    restart_val = '0;
`ifdef UPDOWN_EN
    if (up_dn) begin
      at_term     = (q == LAST);
      q_adv       = at_term ? '0 : q + WIDTH'(1);
      restart_val = '0;
    end else begin
      // Counting down terminates at 0 and wraps back to the top of the range.
      at_term     = (q == '0);
      q_adv       = at_term ? LAST : q - WIDTH'(1);
      restart_val = LAST;
    end
`else
    at_term     = (q == LAST);
    q_adv       = at_term ? '0 : q + WIDTH'(1);
    restart_val = '0;
`endif
  end

endmodule

// File: rtl/mod_counter.sv
// Loadable modulo-N event counter with start/halt/one-shot control, valid/ready
// load port, terminal-count pulse and sticky wrap flag. UPDOWN_EN adds up_dn.
module mod_counter
  import mod_counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             halt,
  input  logic             en,
  input  logic             one_shot,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  input  logic             clr_ovf,
`ifdef UPDOWN_EN
  input  logic             up_dn,
`endif
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf,
  output logic             busy
);

  localparam logic [WIDTH-1:0] LAST  = WIDTH'(last_value(MODULUS));
  localparam logic [31:0]      MOD32 = 32'(MODULUS);

  state_t           state, state_d;
  logic [WIDTH-1:0] q_d, q_adv, restart_val, load_val;
  logic             tc_d, ovf_d, at_term, wrap, load_fire;

  mod_counter_next #(
    .WIDTH  (WIDTH),
    .MODULUS(MODULUS)
  ) u_next (
    .q          (q),
`ifdef UPDOWN_EN
    .up_dn      (up_dn),
`endif
    .q_adv      (q_adv),
    .at_term    (at_term),
    .restart_val(restart_val)
  );

  assign load_ready = (state != RUN);
  assign busy       = (state == RUN);
  assign load_fire  = load_valid && load_ready;
  // Out-of-range loads clamp to the terminal value so q never leaves the sequence.
  assign load_val   = (32'(load_data) >= MOD32) ? LAST : load_data;

  always_comb begin
    state_d = state;
    q_d     = q;
    tc_d    = 1'b0;
    wrap    = 1'b0;
    unique case (state)
      IDLE: begin
        if (load_fire) q_d = load_val;
        if (start)     state_d = RUN;
      end
      RUN: begin
        if (en) begin
          tc_d = at_term;
          wrap = at_term && !one_shot;
          if (at_term && one_shot) state_d = DONE;
          else                     q_d     = q_adv;
        end
        if (halt) state_d = IDLE;
      end
      DONE: begin
        // A load outranks start; start alone restarts from the beginning of the sequence.
        if (load_fire) begin
          q_d     = load_val;
          state_d = start ? RUN : IDLE;
        end else if (start) begin
          q_d     = restart_val;
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
    if (wrap)         ovf_d = 1'b1;
    else if (clr_ovf) ovf_d = 1'b0;
    else              ovf_d = ovf;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      q     <= '0;
      tc    <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      state <= state_d;
      q     <= q_d;
      tc    <= tc_d;
      ovf   <= ovf_d;
    end
  end

endmodule
